// File: rtl/rans_byte_packer_if.sv
// Byte-stream input and packed-word output bundle for rans_byte_packer.
// master: the packer side (consumes bytes, sources words); slave: the environment side.
interface rans_byte_packer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               valid_i;
  logic [7:0]         enc_i;
  logic               flush_i;
  logic               m_valid_o;
  logic               m_ready_i;
  logic [31:0]        m_data_o;
  logic [3:0]         m_keep_o;
  logic               m_last_o;
  logic               overflow_o;
  logic [LEVEL_W-1:0] level_o;

  modport master (
    input  valid_i, enc_i, flush_i, m_ready_i,
    output m_valid_o, m_data_o, m_keep_o, m_last_o, overflow_o, level_o
  );

  modport slave (
    output valid_i, enc_i, flush_i, m_ready_i,
    input  m_valid_o, m_data_o, m_keep_o, m_last_o, overflow_o, level_o
  );
endinterface

// File: rtl/rans_byte_packer.sv
// Packs encoder bytes little-endian into 32-bit words behind a FWFT FIFO; latency 1 byte-to-word.
// Upstream is never stalled: a word arriving at a full FIFO with no pop is dropped and flagged sticky.
module rans_byte_packer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rans_byte_packer_if.master  bus
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } word_t;

  logic [1:0]         bcnt, bcnt_nxt;
  logic [23:0]        hold, hold_nxt;
  logic [31:0]        lane_byte;
  logic [2:0]         fill;
  logic               push;
  word_t              push_word;

  word_t              mem [FIFO_DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               full, pop, accept;
  word_t              head;

  // Holding lanes at or above bcnt are kept zero, so a partial word needs no masking.
  always_comb begin
    bcnt_nxt  = bcnt;
    hold_nxt  = hold;
    push      = 1'b0;
    push_word = '0;
    lane_byte = {24'h0, bus.enc_i} << {bcnt, 3'b000};
    fill      = {1'b0, bcnt} + {2'b00, bus.valid_i};
    if (bus.valid_i && bcnt == 2'd3) begin
      push           = 1'b1;
      push_word.data = {bus.enc_i, hold};
      push_word.keep = 4'hf;
      push_word.last = bus.flush_i;
      bcnt_nxt       = 2'd0;
      hold_nxt       = '0;
    end else if (bus.flush_i) begin
      push           = 1'b1;
      push_word.data = {8'h00, hold} | (bus.valid_i ? lane_byte : 32'h0);
      push_word.keep = (4'd1 << fill) - 4'd1;
      push_word.last = 1'b1;
      bcnt_nxt       = 2'd0;
      hold_nxt       = '0;
    end else if (bus.valid_i) begin
      hold_nxt = hold | lane_byte[23:0];
      bcnt_nxt = bcnt + 2'd1;
    end
  end

  assign full   = (level == LEVEL_W'(FIFO_DEPTH));
  assign pop    = (level != '0) && bus.m_ready_i;
  assign accept = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bcnt     <= '0;
      hold     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      bcnt <= bcnt_nxt;
      hold <= hold_nxt;
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

  // On full+pop+push the write lands in the slot being read out this same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept) mem[wptr] <= push_word;
  end

  assign head          = (level != '0) ? mem[rptr] : '0;
  assign bus.m_valid_o = (level != '0);
  assign bus.m_data_o  = head.data;
  assign bus.m_keep_o  = head.keep;
  assign bus.m_last_o  = head.last;
  assign bus.overflow_o = overflow;
  assign bus.level_o   = level;
endmodule

// File: tb/tb_rans_byte_packer.sv
// Scoreboarded bench for rans_byte_packer: a byte-list model builds expected words and tracks FIFO fill.
module tb_rans_byte_packer;
  localparam int D = 8;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ml      = 0;
  bit   movf    = 0;
  int   n_pop   = 0;
  logic [7:0] mbytes [$];
  word_t      sb [$];

  rans_byte_packer_if #(.FIFO_DEPTH(D)) bus ();

  rans_byte_packer #(.FIFO_DEPTH(D)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs at negedge, check registered outputs, advance the model.
  task automatic cyc(input logic v, input logic [7:0] e, input logic f, input logic r);
    word_t w, ex;
    logic  pop, acc;
    int    n;
    @(negedge clk);
    bus.valid_i   = v;
    bus.enc_i     = e;
    bus.flush_i   = f;
    bus.m_ready_i = r;
    #1;
    chk("m_valid", bus.m_valid_o, ml != 0);
    chk("level", bus.level_o, ml);
    chk("overflow", bus.overflow_o, movf);
    if (ml == 0) begin
      chk("empty_data", bus.m_data_o, 0);
      chk("empty_keep", bus.m_keep_o, 0);
      chk("empty_last", bus.m_last_o, 0);
    end
    pop = (ml != 0) && r;
    if (pop) begin
      n_pop++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        ex = sb.pop_front();
        chk("word_data", bus.m_data_o, ex.d);
        chk("word_keep", bus.m_keep_o, ex.k);
        chk("word_last", bus.m_last_o, ex.l);
      end
    end
    if (v) mbytes.push_back(e);
    acc = 1'b0;
    if (mbytes.size() == 4 || f) begin
      w.d = '0;
      n   = mbytes.size();
      for (int i = 0; i < n; i++) w.d[8*i +: 8] = mbytes[i];
      w.k = 4'((1 << n) - 1);
      w.l = f;
      mbytes.delete();
      acc = (ml < D) || pop;
      if (acc) sb.push_back(w);
      else movf = 1'b1;
    end
    ml = ml + (acc ? 1 : 0) - (pop ? 1 : 0);
  endtask

  // Reset with garbage and a flush on the inputs; the flush must be ignored.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.valid_i   = 1'b1;
    bus.enc_i     = 8'h5a;
    bus.flush_i   = 1'b1;
    bus.m_ready_i = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    ml = 0;
    movf = 1'b0;
    mbytes.delete();
    sb.delete();
    #1;
    chk("rst_valid", bus.m_valid_o, 0);
    chk("rst_data", bus.m_data_o, 0);
    chk("rst_keep", bus.m_keep_o, 0);
    chk("rst_last", bus.m_last_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    chk("rst_level", bus.level_o, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && ml > 0; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.enc_i = 8'h00;
    bus.flush_i = 1'b0;
    bus.m_ready_i = 1'b0;
    do_reset();

    // Basic full word
    cyc(1, 8'h11, 0, 1); cyc(1, 8'h22, 0, 1); cyc(1, 8'h33, 0, 1); cyc(1, 8'h44, 0, 1);
    cyc(0, 8'h00, 0, 0);
    chk("t1_valid", bus.m_valid_o, 1);
    chk("t1_data", bus.m_data_o, 32'h44332211);
    chk("t1_keep", bus.m_keep_o, 4'hf);
    chk("t1_last", bus.m_last_o, 0);
    cyc(0, 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 1);
    chk("t1_level0", bus.level_o, 0);

    // Flush shapes: 2 held bytes, flush with 3rd, flush with 4th, bare flush, flush with lone byte
    cyc(1, 8'hA1, 0, 0); cyc(1, 8'hB2, 0, 0); cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 0);
    chk("t2_data", bus.m_data_o, 32'h0000B2A1);
    chk("t2_keep", bus.m_keep_o, 4'b0011);
    chk("t2_last", bus.m_last_o, 1);
    cyc(1, 8'hC1, 0, 0); cyc(1, 8'hC2, 0, 0); cyc(1, 8'hC3, 1, 0);
    cyc(1, 8'hD1, 0, 0); cyc(1, 8'hD2, 0, 0); cyc(1, 8'hD3, 0, 0); cyc(1, 8'hD4, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'hE7, 1, 0);
    cyc(0, 8'h00, 0, 0);
    chk("t3_level", bus.level_o, 5);
    drain();

    // Overflow: 9 words with no ready
    for (int i = 0; i < 36; i++) cyc(1, 8'(i + 1), 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("ovf_level", bus.level_o, 8);
    chk("ovf_flag", bus.overflow_o, 1);
    n_pop = 0;
    drain();
    chk("ovf_drain_cnt", n_pop, 8);
    chk("ovf_sticky", bus.overflow_o, 1);

    // Full FIFO, pop and push on the same cycle
    do_reset();
    for (int i = 0; i < 35; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(1, 8'hEE, 0, 1);
    cyc(0, 8'h00, 0, 0);
    chk("fpp_level", bus.level_o, 8);
    chk("fpp_ovf", bus.overflow_o, 0);
    drain();

    // Reset mid-frame, then a clean lane-0 word
    for (int i = 0; i < 14; i++) cyc(1, 8'(8'h90 + i), 0, 0);
    do_reset();
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0); cyc(1, 8'h03, 0, 0); cyc(1, 8'h04, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk("mr_data", bus.m_data_o, 32'h04030201);
    chk("mr_keep", bus.m_keep_o, 4'hf);
    chk("mr_level", bus.level_o, 1);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0, ($urandom % 3) != 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
